stream_arbiter: RTL and testbench

//  Shares one 32-bit stb/ack output stream (e.g. output_rs232_tx) between N producer

---
 rtl/stream_arbiter.sv | 95 +++++++++
 tb/tb_stream_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// rtl/stream_arbiter.sv - round-robin N:1 stb/ack stream arbiter with optional burst hold
// Registers each granted word and forwards it; flags output-side protocol errors.
module stream_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 1,
  parameter int GW        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   input_data,
  input  logic [N-1:0]         input_stb,
  output logic [N-1:0]         input_ack,
  output logic [WIDTH-1:0]     output_data,
  output logic                 output_stb,
  input  logic                 output_ack,
  output logic [GW-1:0]        grant,
  output logic                 exception
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

  state_t           state;
  logic [BW-1:0]    burst_cnt;
  logic [WIDTH-1:0] words [N];
  logic [GW-1:0]    scan_idx;
  logic [GW-1:0]    rr_sel;
  logic             rr_found;
  logic             hold_burst;
  logic [GW-1:0]    sel;

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = input_data[i*WIDTH +: WIDTH];
  end

  // Scan starts one past the last grant and ends on the last grant itself,
  // so a lone requester is always re-granted.
  always_comb begin
    rr_sel   = grant;
    rr_found = 1'b0;
    scan_idx = grant;
    for (int k = 1; k <= N; k++) begin
      scan_idx = GW'((int'(grant) + k) % N);
      if (!rr_found && input_stb[scan_idx]) begin
        rr_sel   = scan_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign hold_burst = (MAX_BURST > 1) && input_stb[grant] && (burst_cnt < BURST_LAST);
  assign sel        = hold_burst ? grant : rr_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      output_stb  <= 1'b0;
      output_data <= '0;
      input_ack   <= '0;
      grant       <= GW'(N - 1);
      burst_cnt   <= '0;
      exception   <= 1'b0;
    end else begin
      if ((output_ack && !output_stb) || (state == SEND && !input_stb[grant]))
        exception <= 1'b1;
      case (state)
        IDLE: begin
          if (|input_stb) begin
            grant       <= sel;
            output_data <= words[sel];
            output_stb  <= 1'b1;
            burst_cnt   <= hold_burst ? burst_cnt + BW'(1) : '0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (output_ack) begin
            output_stb       <= 1'b0;
            input_ack[grant] <= 1'b1;
            state            <= ACK;
          end
        end
        ACK: begin
          input_ack <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// tb/tb_stream_arbiter.sv - self-checking bench for stream_arbiter
// Vector table, hand-written corner sequences and a randomized run against a round-robin model.
module tb_stream_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] in_data = '0, b_data = '0;
  logic [3:0]   in_stb = '0, b_stb = '0;
  logic [3:0]   in_ack, b_in_ack;
  logic [31:0]  out_data, b_out_data;
  logic         out_stb, b_out_stb;
  logic         out_ack = 1'b0, b_out_ack = 1'b0;
  logic [1:0]   grant, b_grant;
  logic         exc, b_exc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_arbiter #(.N(4), .WIDTH(32), .MAX_BURST(1), .GW(2)) dut (
    .clk(clk), .rst(rst), .input_data(in_data), .input_stb(in_stb), .input_ack(in_ack),
    .output_data(out_data), .output_stb(out_stb), .output_ack(out_ack),
    .grant(grant), .exception(exc)
  );

  stream_arbiter #(.N(4), .WIDTH(32), .MAX_BURST(3), .GW(2)) dut_b (
    .clk(clk), .rst(rst), .input_data(b_data), .input_stb(b_stb), .input_ack(b_in_ack),
    .output_data(b_out_data), .output_stb(b_out_stb), .output_ack(b_out_ack),
    .grant(b_grant), .exception(b_exc)
  );

  typedef struct {
    logic [3:0] stb;
    logic [1:0] g;
  } vec_t;

  vec_t tbl[12];
  int   burst_exp[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] s);
    for (int k = 1; k <= 4; k++)
      if (s[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  bit          pend[4];
  logic [31:0] word[4];
  int          last_g;
  int          exp_g;
  int          n;
  logic        p_stb;
  logic [1:0]  p_grant;
  logic [31:0] p_data;
  logic        a;
  logic [3:0]  stb_drv;

  initial begin
    tbl[0]  = '{4'b1111, 2'd1};  tbl[1]  = '{4'b1111, 2'd2};
    tbl[2]  = '{4'b1111, 2'd3};  tbl[3]  = '{4'b1111, 2'd0};
    tbl[4]  = '{4'b0001, 2'd0};  tbl[5]  = '{4'b0001, 2'd0};
    tbl[6]  = '{4'b1001, 2'd3};  tbl[7]  = '{4'b1001, 2'd0};
    tbl[8]  = '{4'b0100, 2'd2};  tbl[9]  = '{4'b0011, 2'd0};
    tbl[10] = '{4'b0010, 2'd1};  tbl[11] = '{4'b1100, 2'd2};
    burst_exp = '{0, 0, 0, 2, 2, 2, 0, 0, 0, 1, 1, 1, 1};

    // reset state
    tick(); tick();
    chk("rst_out_stb", 32'(out_stb), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ack", 32'(in_ack), 0);
    chk("rst_grant", 32'(grant), 3);
    chk("rst_exception", 32'(exc), 0);
    chk("rst_b_grant", 32'(b_grant), 3);

    // single word from requester 0
    in_data[31:0] = 32'h41;
    in_stb = 4'b0001;
    rst = 1'b1;
    tick();
    chk("t1_out_stb", 32'(out_stb), 1);
    chk("t1_out_data", out_data, 32'h41);
    chk("t1_grant", 32'(grant), 0);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("t1_in_ack", 32'(in_ack), 32'b0001);
    chk("t1_out_stb_low", 32'(out_stb), 0);
    in_stb = 4'b0000;
    tick();
    chk("t1_in_ack_pulse", 32'(in_ack), 0);

    // burst hold on the MAX_BURST=3 instance, then a lone requester
    for (int w = 0; w < 13; w++) begin
      b_stb = (w < 9) ? 4'b0101 : 4'b0010;
      for (int i = 0; i < 4; i++) b_data[i*32 +: 32] = 32'h1000 * i + w;
      n = 0;
      while (!b_out_stb && n < 20) begin tick(); n++; end
      chk("burst_timeout", 32'(n < 20), 1);
      chk("burst_grant", 32'(b_grant), burst_exp[w]);
      chk("burst_data", b_out_data, 32'h1000 * burst_exp[w] + w);
      b_out_ack = 1'b1;
      tick();
      b_out_ack = 1'b0;
      chk("burst_in_ack", 32'(b_in_ack), 32'(1) << burst_exp[w]);
      if (w == 12) b_stb = 4'b0000;
      tick();
    end
    chk("burst_exception", 32'(b_exc), 0);

    // round-robin vector table
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h100 * i + v;
      in_stb = tbl[v].stb;
      tick();
      chk("tbl_out_stb", 32'(out_stb), 1);
      chk("tbl_grant", 32'(grant), 32'(tbl[v].g));
      chk("tbl_data", out_data, 32'h100 * tbl[v].g + v);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      chk("tbl_in_ack", 32'(in_ack), 32'(1) << tbl[v].g);
      in_stb = 4'b0000;
      tick();
      chk("tbl_in_ack_clear", 32'(in_ack), 0);
    end

    // output stalled for 10 cycles, input data changing underneath
    in_data[63:32] = 32'h5555;
    in_stb = 4'b0010;
    tick();
    chk("stall_grant", 32'(grant), 1);
    for (int c = 0; c < 10; c++) begin
      in_data[63:32] = $urandom;
      tick();
      chk("stall_out_stb", 32'(out_stb), 1);
      chk("stall_data", out_data, 32'h5555);
      chk("stall_in_ack", 32'(in_ack), 0);
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("stall_done_ack", 32'(in_ack), 32'b0010);
    in_stb = 4'b0000;
    tick();
    chk("clean_exception", 32'(exc), 0);

    // spurious output_ack sets the sticky exception
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("exc_set", 32'(exc), 1);
    tick();
    chk("exc_sticky", 32'(exc), 1);
    in_data[31:0] = 32'h77;
    in_stb = 4'b0001;
    tick();
    chk("exc_xfer_data", out_data, 32'h77);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("exc_xfer_ack", 32'(in_ack), 32'b0001);
    in_stb = 4'b0000;
    tick();
    chk("exc_still_set", 32'(exc), 1);

    // reset during SEND with grant 2
    in_stb = 4'b0100;
    tick();
    chk("rsend_grant", 32'(grant), 2);
    chk("rsend_out_stb", 32'(out_stb), 1);
    #2 rst = 1'b0;
    #1;
    chk("rsend_out_stb_drop", 32'(out_stb), 0);
    chk("rsend_in_ack", 32'(in_ack), 0);
    chk("rsend_grant_rst", 32'(grant), 3);
    chk("rsend_exc_clr", 32'(exc), 0);
    tick();
    in_stb = 4'b0101;
    rst = 1'b1;
    tick();
    chk("rsend_first_winner", 32'(grant), 0);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("rsend_first_ack", 32'(in_ack), 32'b0001);
    in_stb = 4'b0000;

    // randomized traffic against a round-robin transaction model
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin pend[i] = 0; word[i] = '0; end
    last_g = 3;
    p_stb = 1'b0;
    p_grant = 2'd3;
    p_data = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (in_ack[i]) pend[i] = 0;
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1;
          word[i] = $urandom;
        end
        in_stb[i] = pend[i];
        in_data[i*32 +: 32] = word[i];
      end
      stb_drv = in_stb;
      a = 1'($urandom_range(1));
      out_ack = a;
      tick();
      chk("rnd_in_ack", 32'(in_ack), (p_stb && a) ? (32'(1) << p_grant) : 32'd0);
      if (out_stb && !p_stb) begin
        exp_g = rr_pick(last_g, stb_drv);
        chk("rnd_grant", 32'(grant), exp_g);
        chk("rnd_data", out_data, word[exp_g]);
        last_g = exp_g;
      end else if (p_stb && !a) begin
        chk("rnd_hold_stb", 32'(out_stb), 1);
        chk("rnd_hold_data", out_data, p_data);
      end
      p_stb = out_stb;
      p_grant = grant;
      p_data = out_data;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
